cfg_bank_bl_wl_driver: RTL and testbench

- Programming-side driver for memory-bank style configuration. It accepts configuration words (word-line address plus bit-line data) over a valid/ready handshake, and sequences the shared bit-line and one-hot word-line buses through setup, pulse and hold phases.
- Sits directly upstream of the IO grid columns (for example, the 8-tile left IO column). Its bl/wl outputs connect straight to those columns' bl[0:7] and wl[0:7] inputs.
- Runs entirely in the programming clock domain.

---
 rtl/cfg_bank_pkg.sv | 28 ++
 rtl/cfg_bank_wl_decoder.sv | 21 ++
 rtl/cfg_bank_bl_wl_driver.sv | 184 ++++++++++++++++++
 tb/tb_cfg_bank_bl_wl_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_bank_pkg.sv
// Shared types and constants for the configuration-bank bit-line/word-line driver.
package cfg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Phase timer must hold the longest phase length minus one.
  function automatic int timer_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
    int max_cyc;
    max_cyc = setup_cyc;
    if (pulse_cyc > max_cyc) max_cyc = pulse_cyc;
    else                     max_cyc = max_cyc;
    if (hold_cyc > max_cyc)  max_cyc = hold_cyc;
    else                     max_cyc = max_cyc;
    return $clog2(max_cyc + 1);
  endfunction

  localparam int DEF_TMR_W = timer_width(DEF_SETUP_CYC, DEF_PULSE_CYC, DEF_HOLD_CYC);

endpackage

// File: rtl/cfg_bank_wl_decoder.sv
// Word-line address to one-hot decoder; out-of-range addresses decode to all-zero.
module cfg_bank_wl_decoder #(
  parameter int NUM_WL    = 8,
  parameter int WL_ADDR_W = 3
) (
  input  logic                 en_i,
  input  logic [WL_ADDR_W-1:0] addr_i,
  output logic [0:NUM_WL-1]    wl_o,
  output logic                 in_range_o
);

  // Range check and one-hot decode
  always_comb begin
    wl_o       = '0;
    in_range_o = ({1'b0, addr_i} < (WL_ADDR_W + 1)'(NUM_WL));
    for (int i = 0; i < NUM_WL; i++) begin
      wl_o[i] = en_i && in_range_o && (addr_i == WL_ADDR_W'(i));
    end
  end

endmodule

// File: rtl/cfg_bank_bl_wl_driver.sv
// Configuration-bank programming driver: accepts (wl address, bl data) words and
// sequences the shared bit-lines and one-hot word-lines through setup/pulse/hold.
module cfg_bank_bl_wl_driver
  import cfg_bank_pkg::*;
#(
  parameter int NUM_BL    = 8,
  parameter int NUM_WL    = 8,
  parameter int WL_ADDR_W = 3,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CNT_W     = 16
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WL_ADDR_W-1:0] cfg_wl_addr,
  input  logic [NUM_BL-1:0]    cfg_bl_data,
  input  logic                 cfg_last,
  output logic [0:NUM_BL-1]    bl,
  output logic [0:NUM_WL-1]    wl,
  output logic                 busy,
  output logic                 done,
  output logic                 addr_err,
  output logic [CNT_W-1:0]     word_count
);

  localparam int TMR_W = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [WL_ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_BL-1:0]      data_q, data_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic [0:NUM_BL-1]      bl_q, bl_d;
  logic [0:NUM_WL-1]      wl_q, wl_s;
  logic                   in_range_s;
  logic                   accept_s;
  logic                   tmr_zero_s;

  assign accept_s   = cfg_valid && ready_q && (state_q == ST_IDLE);
  assign tmr_zero_s = (tmr_q == '0);

  // Phase sequencing; the single down-counter is reloaded on every state entry
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SETUP;
          tmr_d   = SETUP_LD;
        end else begin
          state_d = ST_IDLE;
          tmr_d   = tmr_q;
        end
      end
      ST_SETUP: begin
        if (tmr_zero_s) begin
          state_d = ST_PULSE;
          tmr_d   = PULSE_LD;
        end else begin
          tmr_d   = tmr_q - TMR_ONE;
        end
      end
      ST_PULSE: begin
        if (tmr_zero_s) begin
          state_d = ST_HOLD;
          tmr_d   = HOLD_LD;
        end else begin
          tmr_d   = tmr_q - TMR_ONE;
        end
      end
      ST_HOLD: begin
        if (tmr_zero_s) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d   = tmr_q - TMR_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Word capture, saturating word counter and the done flag
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (accept_s) begin
      addr_d = cfg_wl_addr;
      data_d = cfg_bl_data;
      last_d = cfg_last;
      done_d = 1'b0;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      else                  cnt_d = cnt_q;
    end else if ((state_q == ST_HOLD) && tmr_zero_s && last_q) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end
  end

  cfg_bank_wl_decoder #(
    .NUM_WL    (NUM_WL),
    .WL_ADDR_W (WL_ADDR_W)
  ) u_wl_dec (
    .en_i       (state_d == ST_PULSE),
    .addr_i     (addr_d),
    .wl_o       (wl_s),
    .in_range_o (in_range_s)
  );

  // Output next-values are derived from the next state so every output is a flop
  always_comb begin
    err_d = err_q;
    if (accept_s && !in_range_s) err_d = 1'b1;
    else                         err_d = err_q;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    bl_d    = '0;
    for (int i = 0; i < NUM_BL; i++) begin
      bl_d[i] = (state_d != ST_IDLE) ? data_d[i] : 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      bl_q    <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      bl_q    <= bl_d;
      wl_q    <= wl_s;
    end
  end

  assign cfg_ready  = ready_q;
  assign bl         = bl_q;
  assign wl         = wl_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign addr_err   = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_cfg_bank_bl_wl_driver.sv
// Scoreboard bench: dut A uses default timing with a 4-bit address; dut B uses
// a long pulse/hold and a 2-bit word counter.
module tb_cfg_bank_bl_wl_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_last, a_busy, a_done, a_err;
  logic [3:0]  a_addr;
  logic [7:0]  a_data;
  logic [0:7]  a_bl, a_wl;
  logic [15:0] a_cnt;

  logic        b_valid, b_ready, b_last, b_busy, b_done, b_err;
  logic [2:0]  b_addr;
  logic [7:0]  b_data;
  logic [0:7]  b_bl, b_wl;
  logic [1:0]  b_cnt;

  cfg_bank_bl_wl_driver #(.WL_ADDR_W(4)) u_dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .cfg_wl_addr(a_addr), .cfg_bl_data(a_data), .cfg_last(a_last), .bl(a_bl), .wl(a_wl),
    .busy(a_busy), .done(a_done), .addr_err(a_err), .word_count(a_cnt)
  );

  cfg_bank_bl_wl_driver #(.WL_ADDR_W(3), .PULSE_CYC(4), .HOLD_CYC(3), .CNT_W(2)) u_dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_wl_addr(b_addr), .cfg_bl_data(b_data), .cfg_last(b_last), .bl(b_bl), .wl(b_wl),
    .busy(b_busy), .done(b_done), .addr_err(b_err), .word_count(b_cnt)
  );

  typedef struct packed {
    logic [7:0] bl;
    logic [7:0] wl;
    logic       ready;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bl[i] follows data bit i; bl[0] is the leftmost (most significant) bit of the bus value
  function automatic logic [7:0] bl_vec(input logic [7:0] data);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = data[i];
    return r;
  endfunction

  function automatic logic [7:0] wl_vec(input int addr);
    logic [7:0] r;
    r = 8'h00;
    if (addr < 8) r[7-addr] = 1'b1;
    return r;
  endfunction

  // Expected per-cycle outputs for one word, starting with the cycle after the accept edge
  function automatic void push_trace(input int dut, input logic [7:0] data, input int addr, input logic last);
    int s, p, h;
    exp_t e;
    if (dut == 0) begin s = 1; p = 2; h = 1; end
    else          begin s = 1; p = 4; h = 3; end
    for (int c = 1; c <= s + p + h + 1; c++) begin
      e.bl    = (c <= s + p + h) ? bl_vec(data) : 8'h00;
      e.wl    = (c > s && c <= s + p) ? wl_vec(addr) : 8'h00;
      e.ready = (c == s + p + h + 1);
      e.busy  = !e.ready;
      e.done  = e.ready ? last : 1'b0;
      if (dut == 0) qa.push_back(e);
      else          qb.push_back(e);
    end
  endfunction

  task automatic send_word(input int dut, input int addr, input logic [7:0] data,
                           input logic last, input bit more, input bit disturb);
    int len;
    len = (dut == 0) ? 5 : 9;
    if (dut == 0) begin a_valid = 1'b1; a_addr = 4'(addr); a_data = data; a_last = last; end
    else          begin b_valid = 1'b1; b_addr = 3'(addr); b_data = data; b_last = last; end
    @(posedge clk); #1;
    push_trace(dut, data, addr, last);
    for (int k = 0; k < len - 1; k++) begin
      if (disturb && dut == 1) begin
        b_valid = 1'($urandom);
        b_data  = 8'($urandom);
        b_addr  = 3'($urandom);
      end
      @(posedge clk); #1;
    end
    if (!more) begin
      if (dut == 0) a_valid = 1'b0;
      else          b_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      check_val("a_bl",    32'(a_bl),    32'(ea.bl));
      check_val("a_wl",    32'(a_wl),    32'(ea.wl));
      check_val("a_ready", 32'(a_ready), 32'(ea.ready));
      check_val("a_busy",  32'(a_busy),  32'(ea.busy));
      check_val("a_done",  32'(a_done),  32'(ea.done));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      check_val("b_bl",    32'(b_bl),    32'(eb.bl));
      check_val("b_wl",    32'(b_wl),    32'(eb.wl));
      check_val("b_ready", 32'(b_ready), 32'(eb.ready));
      check_val("b_busy",  32'(b_busy),  32'(eb.busy));
      check_val("b_done",  32'(b_done),  32'(eb.done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    rst_n   = 1'b0;
    a_valid = 1'b0; a_addr = 4'd0; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b0; b_addr = 3'd0; b_data = 8'h00; b_last = 1'b0;
    #12;
    check_val("rst_ready", 32'(a_ready), 32'd0);
    check_val("rst_bl",    32'(a_bl),    32'd0);
    check_val("rst_wl",    32'(a_wl),    32'd0);
    check_val("rst_busy",  32'(a_busy),  32'd0);
    check_val("rst_done",  32'(a_done),  32'd0);
    check_val("rst_err",   32'(a_err),   32'd0);
    check_val("rst_cnt",   32'(a_cnt),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rel_ready_a", 32'(a_ready), 32'd1);
    check_val("rel_ready_b", 32'(b_ready), 32'd1);

    // single word
    send_word(0, 3, 8'hA5, 1'b1, 1'b0, 1'b0);
    check_val("single_cnt",  32'(a_cnt),  32'd1);
    check_val("single_done", 32'(a_done), 32'd1);

    // eight back-to-back words, non-palindromic data exposes bit ordering
    for (int w = 0; w < 8; w++) begin
      d = 8'h01 << w;
      send_word(0, w, d, (w == 7), (w != 7), 1'b0);
    end
    check_val("b2b_cnt",  32'(a_cnt),  32'd9);
    check_val("b2b_done", 32'(a_done), 32'd1);

    // out-of-range address, then a normal word
    send_word(0, 9, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("oor_err",  32'(a_err),  32'd1);
    check_val("oor_done", 32'(a_done), 32'd0);
    send_word(0, 2, 8'h3C, 1'b1, 1'b0, 1'b0);
    check_val("oor_err_sticky", 32'(a_err), 32'd1);
    check_val("oor_cnt",        32'(a_cnt), 32'd11);

    // reset in the middle of a pulse
    a_valid = 1'b1; a_addr = 4'd5; a_data = 8'h5A; a_last = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    check_val("mid_wl_pre", 32'(a_wl), 32'(wl_vec(5)));
    check_val("mid_bl_pre", 32'(a_bl), 32'(bl_vec(8'h5A)));
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_wl",    32'(a_wl),    32'd0);
    check_val("mid_bl",    32'(a_bl),    32'd0);
    check_val("mid_cnt",   32'(a_cnt),   32'd0);
    check_val("mid_done",  32'(a_done),  32'd0);
    check_val("mid_err",   32'(a_err),   32'd0);
    check_val("mid_ready", 32'(a_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rel_ready", 32'(a_ready), 32'd1);
    check_val("mid_rel_busy",  32'(a_busy),  32'd0);

    // long pulse/hold, inputs disturbed while busy, counter saturation
    for (int n = 1; n <= 5; n++) begin
      d = 8'h1E + 8'(n * 17);
      send_word(1, (n * 3) % 8, d, (n == 5), (n != 5), (n == 1));
      check_val("sat_cnt", 32'(b_cnt), (n < 3) ? 32'(n) : 32'd3);
    end
    check_val("sat_done", 32'(b_done), 32'd1);
    check_val("sat_err",  32'(b_err),  32'd0);

    repeat (3) @(posedge clk);
    #1;
    check_val("qa_drained", 32'(qa.size()), 32'd0);
    check_val("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
